// File: rtl/codificador_tx_hamming.sv
// Transmit side of the Hamming SECDED (8,4) link: encodes a 4-bit word, optionally
// injects an error mask, and shifts it out LSB first in a start/data/stop frame.
module codificador_tx_hamming #(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dato_in,
    input  logic [7:0] mascara_error,
    input  logic       valid_in,
    output logic       ready_out,
    output logic [7:0] palabra_tx,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {IDLE, START, DATOS, STOP} estado_t;

    localparam logic [7:0] ULTIMO_CICLO = 8'(CICLOS_POR_BIT - 1);

    estado_t     estado_q, estado_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  indice_q, indice_d;
    logic [7:0]  palabra_q, palabra_d;
    logic        serial_q, serial_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  codificada;
    logic        aceptar;
    logic        fin_bit;

    // Bit map {g0,w3,w2,w1,p2,w0,p1,p0}; g0 makes the overall parity even.
    always_comb begin
        codificada[0] = dato_in[0] ^ dato_in[1] ^ dato_in[3];
        codificada[1] = dato_in[0] ^ dato_in[2] ^ dato_in[3];
        codificada[2] = dato_in[0];
        codificada[3] = dato_in[1] ^ dato_in[2] ^ dato_in[3];
        codificada[4] = dato_in[1];
        codificada[5] = dato_in[2];
        codificada[6] = dato_in[3];
        codificada[7] = ^codificada[6:0];
    end

    assign aceptar = valid_in & ready_q;
    assign fin_bit = (cnt_q == ULTIMO_CICLO);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= IDLE;
            cnt_q     <= 8'd0;
            indice_q  <= 3'd0;
            palabra_q <= 8'h00;
            serial_q  <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            cnt_q     <= cnt_d;
            indice_q  <= indice_d;
            palabra_q <= palabra_d;
            serial_q  <= serial_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        cnt_d     = cnt_q;
        indice_d  = indice_q;
        palabra_d = palabra_q;
        unique case (estado_q)
            IDLE: begin
                cnt_d    = 8'd0;
                indice_d = 3'd0;
                if (aceptar) begin
                    palabra_d = codificada ^ mascara_error;
                    estado_d  = START;
                end
            end
            START: begin
                if (fin_bit) begin
                    cnt_d    = 8'd0;
                    indice_d = 3'd0;
                    estado_d = DATOS;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATOS: begin
                if (fin_bit) begin
                    cnt_d = 8'd0;
                    if (indice_q == 3'd7) begin
                        estado_d = STOP;
                    end else begin
                        indice_d = indice_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STOP: begin
                if (fin_bit) begin
                    cnt_d    = 8'd0;
                    estado_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: estado_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered copies line up with it.
    always_comb begin
        serial_d = 1'b1;
        ready_d  = (estado_d == IDLE);
        busy_d   = (estado_d != IDLE);
        done_d   = (estado_q == STOP) && (estado_d == IDLE);
        unique case (estado_d)
            START:   serial_d = 1'b0;
            DATOS:   serial_d = palabra_q[indice_d];
            default: serial_d = 1'b1;
        endcase
    end

    assign ready_out  = ready_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_serial  = serial_q;
    assign palabra_tx = palabra_q;

endmodule

// File: tb/tb_codificador_tx_hamming.sv
// Self-checking bench for codificador_tx_hamming: encoding table with a SECDED decode
// model, serial framing, back-to-back handshake, reset behaviour, N=4 and N=1.
module tb_codificador_tx_hamming;

    logic       clk = 1'b0;
    logic       rst4, valid4, rst1, valid1;
    logic [3:0] dato4, dato1;
    logic [7:0] mask4, mask1;
    logic       ready4, ser4, busy4, done4;
    logic       ready1, ser1, busy1, done1;
    logic [7:0] pal4, pal1;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    codificador_tx_hamming #(.CICLOS_POR_BIT(4)) dut4 (
        .clk(clk), .rst(rst4), .dato_in(dato4), .mascara_error(mask4), .valid_in(valid4),
        .ready_out(ready4), .palabra_tx(pal4), .tx_serial(ser4), .tx_busy(busy4), .tx_done(done4)
    );

    codificador_tx_hamming #(.CICLOS_POR_BIT(1)) dut1 (
        .clk(clk), .rst(rst1), .dato_in(dato1), .mascara_error(mask1), .valid_in(valid1),
        .ready_out(ready1), .palabra_tx(pal1), .tx_serial(ser1), .tx_busy(busy1), .tx_done(done1)
    );

    typedef struct {
        logic [3:0] dato;
        logic [7:0] mask;
        logic [7:0] expWord;
        logic [3:0] expData;
        logic [1:0] expClass;
    } vector_t;

    vector_t tabla[7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Receive-side SECDED corrector model: returns {class, data}; class 0 clean, 1 corrected, 2 double.
    function automatic logic [5:0] decode(input logic [7:0] w);
        logic [2:0] s;
        logic       par;
        logic [7:0] c;
        logic [1:0] cls;
        s[0] = w[0] ^ w[2] ^ w[4] ^ w[6];
        s[1] = w[1] ^ w[2] ^ w[5] ^ w[6];
        s[2] = w[3] ^ w[4] ^ w[5] ^ w[6];
        par  = ^w;
        c    = w;
        cls  = 2'd0;
        if (s != 3'd0 && par) begin
            c[int'(s) - 1] = ~c[int'(s) - 1];
            cls = 2'd1;
        end else if (s != 3'd0) begin
            cls = 2'd2;
        end else if (par) begin
            cls = 2'd1;
        end
        return {cls, c[6], c[5], c[4], c[2]};
    endfunction

    task automatic sample(input bit sel, output logic s, output logic r, output logic b,
                          output logic d, output logic [7:0] p);
        s = sel ? ser1 : ser4;
        r = sel ? ready1 : ready4;
        b = sel ? busy1 : busy4;
        d = sel ? done1 : done4;
        p = sel ? pal1 : pal4;
    endtask

    task automatic checkIdle(input bit sel, input string tag);
        logic s, r, b, d;
        logic [7:0] p;
        sample(sel, s, r, b, d, p);
        checkOutput({tag, " tx_serial"}, 32'(s), 32'd1);
        checkOutput({tag, " ready_out"}, 32'(r), 32'd1);
        checkOutput({tag, " tx_busy"}, 32'(b), 32'd0);
        checkOutput({tag, " tx_done"}, 32'(d), 32'd0);
        checkOutput({tag, " palabra_tx"}, 32'(p), 32'h00);
    endtask

    // Called at a negedge with the block idle; returns at the negedge just after the accept edge.
    task automatic applyStimulus(input bit sel, input logic [3:0] dato, input logic [7:0] mask,
                                 input bit hold);
        logic s, r, b, d;
        logic [7:0] p;
        sample(sel, s, r, b, d, p);
        checkOutput("ready before accept", 32'(r), 32'd1);
        if (sel) begin
            dato1 = dato; mask1 = mask; valid1 = 1'b1;
        end else begin
            dato4 = dato; mask4 = mask; valid4 = 1'b1;
        end
        @(negedge clk);
        if (!hold) begin
            valid1 = 1'b0;
            valid4 = 1'b0;
        end
        sample(sel, s, r, b, d, p);
        checkOutput("busy after accept", 32'(b), 32'd1);
    endtask

    // Walks one frame from cycle 0 and ends on the tx_done cycle.
    task automatic runFrame(input bit sel, input int n, input logic [7:0] word, input bit scramble);
        logic [9:0] frm;
        logic s, r, b, d;
        logic [7:0] p;
        int errSer, errDone, errHs, errPal;
        frm = {1'b1, word, 1'b0};
        errSer = 0; errDone = 0; errHs = 0; errPal = 0;
        for (int i = 0; i < 10 * n; i++) begin
            sample(sel, s, r, b, d, p);
            if (s !== frm[i / n]) errSer++;
            if (d !== 1'b0) errDone++;
            if (r !== 1'b0 || b !== 1'b1) errHs++;
            if (p !== word) errPal++;
            if (scramble) begin
                dato4 = 4'($urandom);
                mask4 = 8'($urandom);
            end
            @(negedge clk);
        end
        sample(sel, s, r, b, d, p);
        checkOutput("frame serial bit errors", 32'(errSer), 32'd0);
        checkOutput("tx_done inside frame", 32'(errDone), 32'd0);
        checkOutput("handshake inside frame", 32'(errHs), 32'd0);
        checkOutput("palabra_tx stable in frame", 32'(errPal), 32'd0);
        checkOutput("tx_done at frame end", 32'(d), 32'd1);
        checkOutput("ready_out with tx_done", 32'(r), 32'd1);
        checkOutput("tx_serial idle at end", 32'(s), 32'd1);
    endtask

    // Asserts reset during data bit 3 and checks the frame is abandoned.
    task automatic resetMidFrame(input bit sel, input int n);
        logic s, r, b, d;
        logic [7:0] p;
        int doneSeen, lowSeen;
        doneSeen = 0; lowSeen = 0;
        for (int i = 0; i < 4 * n + (n > 1 ? 1 : 0); i++) @(negedge clk);
        if (sel) rst1 = 1'b1; else rst4 = 1'b1;
        @(negedge clk);
        rst1 = 1'b0;
        rst4 = 1'b0;
        checkIdle(sel, "after mid-frame reset");
        for (int i = 0; i < 12 * n; i++) begin
            @(negedge clk);
            sample(sel, s, r, b, d, p);
            if (d !== 1'b0) doneSeen++;
            if (s !== 1'b1) lowSeen++;
        end
        checkOutput("no tx_done after abandon", 32'(doneSeen), 32'd0);
        checkOutput("line idle after abandon", 32'(lowSeen), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic s, r, b, d;
        logic [7:0] p;
        logic [5:0] dec;
        int errIdle;

        tabla[0] = '{4'b0000, 8'h00, 8'h00, 4'b0000, 2'd0};
        tabla[1] = '{4'b1011, 8'h00, 8'h55, 4'b1011, 2'd0};
        tabla[2] = '{4'b0001, 8'h00, 8'h87, 4'b0001, 2'd0};
        tabla[3] = '{4'b1111, 8'h00, 8'hFF, 4'b1111, 2'd0};
        tabla[4] = '{4'b1011, 8'h04, 8'h51, 4'b1011, 2'd1};
        tabla[5] = '{4'b1011, 8'h05, 8'h50, 4'b0000, 2'd2};
        tabla[6] = '{4'b1011, 8'h80, 8'hD5, 4'b1011, 2'd1};

        rst4 = 1'b1; rst1 = 1'b1;
        valid4 = 1'b0; valid1 = 1'b0;
        dato4 = 4'h0; dato1 = 4'h0;
        mask4 = 8'h00; mask1 = 8'h00;
        repeat (3) @(negedge clk);
        rst4 = 1'b0;
        checkIdle(0, "reset");

        errIdle = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            sample(0, s, r, b, d, p);
            if (d !== 1'b0 || s !== 1'b1 || r !== 1'b1 || b !== 1'b0 || p !== 8'h00) errIdle++;
        end
        checkOutput("idle 50 cycles", 32'(errIdle), 32'd0);

        rst4 = 1'b1; valid4 = 1'b1; dato4 = 4'b1111;
        @(negedge clk);
        rst4 = 1'b0; valid4 = 1'b0;
        checkIdle(0, "reset beats accept");

        $display("[TB] encoding table and serial frames, N=4");
        foreach (tabla[k]) begin
            @(negedge clk);
            applyStimulus(0, tabla[k].dato, tabla[k].mask, 1'b0);
            checkOutput($sformatf("palabra_tx vec%0d", k), 32'(pal4), 32'(tabla[k].expWord));
            dec = decode(pal4);
            checkOutput($sformatf("corrector class vec%0d", k), 32'(dec[5:4]), 32'(tabla[k].expClass));
            if (tabla[k].expClass != 2'd2)
                checkOutput($sformatf("corrector data vec%0d", k), 32'(dec[3:0]), 32'(tabla[k].dato));
            runFrame(0, 4, tabla[k].expWord, 1'b0);
        end

        $display("[TB] back-to-back with valid_in held high");
        @(negedge clk);
        applyStimulus(0, 4'b1011, 8'h00, 1'b1);
        checkOutput("b2b first word", 32'(pal4), 32'h55);
        runFrame(0, 4, 8'h55, 1'b1);
        dato4 = 4'b0001; mask4 = 8'h00;
        @(negedge clk);
        valid4 = 1'b0;
        checkOutput("b2b second word", 32'(pal4), 32'h87);
        runFrame(0, 4, 8'h87, 1'b1);

        $display("[TB] reset during data bit 3, N=4");
        @(negedge clk);
        applyStimulus(0, 4'b1011, 8'h00, 1'b0);
        resetMidFrame(0, 4);
        applyStimulus(0, 4'b0001, 8'h00, 1'b0);
        checkOutput("word after reset", 32'(pal4), 32'h87);
        runFrame(0, 4, 8'h87, 1'b0);

        $display("[TB] N=1 frames");
        rst1 = 1'b0;
        @(negedge clk);
        checkIdle(1, "N1 reset");
        applyStimulus(1, 4'b1011, 8'h00, 1'b0);
        checkOutput("N1 palabra_tx", 32'(pal1), 32'h55);
        runFrame(1, 1, 8'h55, 1'b0);
        @(negedge clk);
        applyStimulus(1, 4'b1011, 8'h00, 1'b0);
        resetMidFrame(1, 1);
        applyStimulus(1, 4'b1111, 8'h00, 1'b0);
        checkOutput("N1 word after reset", 32'(pal1), 32'hFF);
        runFrame(1, 1, 8'hFF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
